// File: rtl/lcd_text_ctrl.sv
// HD44780 8-bit text refresher: init commands, line 1, optional line 2, cursor home.
// Define LCD_LINE2_EN to enable the second display line (ADDR2/LINE2 steps and buffer half).
module lcd_text_ctrl #(
  parameter int CLK_DIV = 10000000,
  parameter int MSG_LEN = 16,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              char_we,
  input  logic [ADDR_W-1:0] char_addr,
  input  logic [7:0]        char_data,
  output logic              busy,
  output logic              done,
  output logic              rs,
  output logic              rw,
  output logic              en,
  output logic [7:0]        db
);

  localparam int CNT_W = $clog2(CLK_DIV);
`ifdef LCD_LINE2_EN
  localparam int BUF_LEN = 2 * MSG_LEN;
`else
  localparam int BUF_LEN = MSG_LEN;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] EN_HI     = CNT_W'(CLK_DIV / 2);
  localparam logic [4:0]       LAST_CHAR = 5'(MSG_LEN - 1);

  typedef enum logic [2:0] {IDLE, INIT, LINE1, ADDR2, LINE2, HOME, FIN} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [4:0]         idx, idx_nx;
  logic               rs_q;
  logic [7:0]         db_q;
  logic               active;
  logic               step_rs;
  logic [7:0]         step_db;
  logic               step_last;
  logic [7:0]         cur_char;
  int                 rd_idx;
  logic [BUF_LEN*8-1:0] buffer;

  // Character buffer; writes are only accepted while no refresh is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer <= {BUF_LEN{8'h20}};
    end else if (char_we && !busy) begin
      for (int i = 0; i < BUF_LEN; i++) begin
        if (32'(char_addr) == i) buffer[i*8 +: 8] <= char_data;
      end
    end
  end

  always_comb begin
    rd_idx   = int'(idx) + ((state == LINE2) ? MSG_LEN : 0);
    cur_char = 8'h20;
    for (int i = 0; i < BUF_LEN; i++) begin
      if (rd_idx == i) cur_char = buffer[i*8 +: 8];
    end
  end

  always_comb begin
    step_rs   = 1'b0;
    step_db   = 8'h00;
    step_last = 1'b1;
    case (state)
      INIT: begin
        case (idx[1:0])
          2'd0:    step_db = 8'h38;
          2'd1:    step_db = 8'h0C;
          2'd2:    step_db = 8'h06;
          default: step_db = 8'h01;
        endcase
        step_last = (idx == 5'd3);
      end
      LINE1, LINE2: begin
        step_rs   = 1'b1;
        step_db   = cur_char;
        step_last = (idx == LAST_CHAR);
      end
      ADDR2:   step_db = 8'hC0;
      HOME:    step_db = 8'h02;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    active   = (state != IDLE) && (state != FIN);
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = INIT;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      end
      FIN: state_nx = IDLE;
      default: begin
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (step_last) begin
            idx_nx = '0;
            case (state)
              INIT:  state_nx = LINE1;
`ifdef LCD_LINE2_EN
              LINE1: state_nx = ADDR2;
`else
              LINE1: state_nx = HOME;
`endif
              ADDR2: state_nx = LINE2;
              LINE2: state_nx = HOME;
              default: state_nx = FIN;
            endcase
          end else begin
            idx_nx = idx + 5'd1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    endcase

    // Bus value appears at count 0 straight from the step decode, then is held.
    busy = active;
    done = (state == FIN);
    rw   = 1'b0;
    en   = active && (cnt != '0) && (cnt <= EN_HI);
    rs   = (active && cnt == '0) ? step_rs : rs_q;
    db   = (active && cnt == '0) ? step_db : db_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      rs_q  <= 1'b0;
      db_q  <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      if (active && cnt == '0) begin
        rs_q <= step_rs;
        db_q <= step_db;
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Scoreboard bench for lcd_text_ctrl (CLK_DIV=8, MSG_LEN=4); follows LCD_LINE2_EN if defined.
module tb_lcd_text_ctrl;

  localparam int CLK_DIV = 8;
  localparam int MSG_LEN = 4;
`ifdef LCD_LINE2_EN
  localparam bit LINE2   = 1'b1;
  localparam int BUF_LEN = 2 * MSG_LEN;
  localparam int STEPS   = 4 + MSG_LEN + 1 + 1 + MSG_LEN;
`else
  localparam bit LINE2   = 1'b0;
  localparam int BUF_LEN = MSG_LEN;
  localparam int STEPS   = 4 + MSG_LEN + 1;
`endif
  localparam int LATENCY = 1 + STEPS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst, start, char_we;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       busy, done, rs, rw, en;
  logic [7:0] db;

  lcd_text_ctrl #(.CLK_DIV(CLK_DIV), .MSG_LEN(MSG_LEN), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .char_we(char_we),
    .char_addr(char_addr), .char_data(char_data), .busy(busy), .done(done),
    .rs(rs), .rw(rw), .en(en), .db(db)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    logic       exp_stored;
  } wr_vec_t;

  wr_vec_t    vecs[10];
  logic [7:0] model[2*MSG_LEN];
  logic [8:0] sb[$];
  int         checks = 0;
  int         errors = 0;
  int         done_count = 0;
  logic       prev_en = 1'b0;
  logic [7:0] held_db = 8'h00;
  int         en_len = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input wr_vec_t v);
    @(negedge clk);
    char_we   = 1'b1;
    char_addr = v.addr;
    char_data = v.data;
    @(posedge clk);
    #1 char_we = 1'b0;
    if (v.exp_stored) model[v.addr] = v.data;
  endtask

  task automatic pushSequence();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h06});
    sb.push_back({1'b0, 8'h01});
    for (int i = 0; i < MSG_LEN; i++) sb.push_back({1'b1, model[i]});
    if (LINE2) begin
      sb.push_back({1'b0, 8'hC0});
      for (int i = 0; i < MSG_LEN; i++) sb.push_back({1'b1, model[MSG_LEN + i]});
    end
    sb.push_back({1'b0, 8'h02});
  endtask

  task automatic startSequence(input logic do_write, input logic [4:0] waddr, input logic [7:0] wdata);
    @(negedge clk);
    start     = 1'b1;
    char_we   = do_write;
    char_addr = waddr;
    char_data = wdata;
    if (do_write && int'(waddr) < BUF_LEN) model[waddr] = wdata;
    pushSequence();
    @(posedge clk);
    #1;
    start   = 1'b0;
    char_we = 1'b0;
  endtask

  task automatic waitDone(input int elapsed, input string name);
    int n;
    n = elapsed;
    while (n < LATENCY + 50) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    checkOutput({name, "_latency"}, n, LATENCY);
    checkOutput({name, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    checkOutput({name, "_done_width"}, done, 0);
    checkOutput({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Step monitor: each rising en pops one expected {rs,db} and checks the pulse shape.
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
      en_len  = 0;
    end else begin
      if (done) done_count++;
      if (busy) checkOutput("rw_low", rw, 0);
      if (en && !prev_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_step: got %0h expected none", {rs, db});
        end else begin
          checkOutput("step_rs_db", {rs, db}, sb.pop_front());
        end
        held_db = db;
        en_len  = 1;
      end else if (en) begin
        en_len++;
        checkOutput("db_stable", db, held_db);
      end else if (prev_en) begin
        checkOutput("en_width", en_len, CLK_DIV / 2);
      end
      prev_en = en;
    end
  end

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; char_we = 1'b0; char_addr = '0; char_data = '0;
    for (int i = 0; i < 2*MSG_LEN; i++) model[i] = 8'h20;

    vecs[0] = '{5'd0,  8'h41, 1'b1};
    vecs[1] = '{5'd1,  8'h42, 1'b1};
    vecs[2] = '{5'd2,  8'h43, 1'b1};
    vecs[3] = '{5'd3,  8'h44, 1'b1};
    vecs[4] = '{5'd4,  8'h77, LINE2};
    vecs[5] = '{5'd5,  8'h78, LINE2};
    vecs[6] = '{5'd6,  8'h79, LINE2};
    vecs[7] = '{5'd7,  8'h7A, LINE2};
    vecs[8] = '{5'd8,  8'h51, 1'b0};
    vecs[9] = '{5'd31, 8'h52, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_en", en, 0);
    checkOutput("rst_rs", rs, 0);
    checkOutput("rst_rw", rw, 0);
    checkOutput("rst_db", db, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
    startSequence(1'b0, 5'd0, 8'h00);
    waitDone(0, "main");

    // Start and a write to address 2 while busy must both be ignored.
    dc = done_count;
    startSequence(1'b0, 5'd0, 8'h00);
    repeat (19) @(negedge clk);
    start = 1'b1; char_we = 1'b1; char_addr = 5'd2; char_data = 8'h5A;
    @(posedge clk);
    #1 start = 1'b0; char_we = 1'b0;
    waitDone(19, "busy_ignore");
    repeat (3 * CLK_DIV) @(negedge clk);
    checkOutput("busy_ignore_idle", busy, 0);
    checkOutput("busy_ignore_one_done", done_count - dc, 1);

    // Reset during LINE1 while en is low aborts silently and clears the buffer.
    startSequence(1'b0, 5'd0, 8'h00);
    repeat (46) @(negedge clk);
    dc = done_count;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_en", en, 0);
    checkOutput("abort_rs", rs, 0);
    checkOutput("abort_db", db, 8'h00);
    repeat (LATENCY) @(negedge clk);
    checkOutput("abort_no_done", done_count, dc);
    for (int i = 0; i < 2*MSG_LEN; i++) model[i] = 8'h20;
    startSequence(1'b0, 5'd0, 8'h00);
    waitDone(0, "after_reset");

    startSequence(1'b1, 5'd0, 8'h5A);
    waitDone(0, "write_with_start");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
